// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the IF/MEM memory port arbiter
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Owner encoding of the granted requester
  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  // Default RAM read latency in cycles
  localparam int DEFAULT_LAT = 2;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_lat_counter.sv
`default_nettype none
// ============================================================================
// Module      : mem_lat_counter
// Description : Loadable up-counter that flags when the RAM latency is reached
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lat_counter #(
  parameter int LAT = 2
) (
  input  logic Clock,
  input  logic Reset,
  input  logic load,
  input  logic inc,
  output logic done
);

  localparam int CW = $clog2(LAT + 1);

  logic [CW-1:0] count;

  // Load to 1 on issue, then count up once per wait cycle
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(1);
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == CW'(LAT));

endmodule : mem_lat_counter
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Arbitrates IF and MEM stage accesses onto one single-port RAM
//               with fixed read latency; returns data with a ready pulse and
//               drives the pipeline stall.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LAT = DEFAULT_LAT,  // legal range 1..15
  parameter int AW  = 32,
  parameter int DW  = 32
) (
  input  logic          Clock,
  input  logic          Reset,
  // fetch port
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  // data port
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_ready,
  // RAM side
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  // pipeline
  output logic          stall
);

  state_t state, state_nxt;
  logic   owner;
  logic   grant;
  logic   grant_own;
  logic   cnt_load;
  logic   cnt_inc;
  logic   cnt_done;
  logic   capture;

  mem_lat_counter #(
    .LAT (LAT)
  ) u_lat_counter (
    .Clock (Clock),
    .Reset (Reset),
    .load  (cnt_load),
    .inc   (cnt_inc),
    .done  (cnt_done)
  );

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, grant and counter control; MEM wins in IDLE, DONE hands over
  // to the other port so neither requester can starve the other
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_own = OWN_IF;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_req) begin
          grant     = 1'b1;
          grant_own = OWN_MEM;
          state_nxt = ST_ISSUE;
        end else if (if_req) begin
          grant     = 1'b1;
          grant_own = OWN_IF;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_load  = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_inc = 1'b1;
        if (cnt_done) begin
          capture   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        if (owner == OWN_MEM && if_req) begin
          grant     = 1'b1;
          grant_own = OWN_IF;
          state_nxt = ST_ISSUE;
        end else if (owner == OWN_IF && mem_req) begin
          grant     = 1'b1;
          grant_own = OWN_MEM;
          state_nxt = ST_ISSUE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Latch owner and request on grant; the RAM-side registers double as the
  // latched request so later requester changes are ignored
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      owner     <= OWN_IF;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else if (grant) begin
      owner <= grant_own;
      if (grant_own == OWN_MEM) begin
        ram_we    <= mem_we;
        ram_addr  <= mem_addr;
        ram_wdata <= mem_wdata;
      end else begin
        ram_we    <= 1'b0;
        ram_addr  <= if_addr;
        ram_wdata <= '0;
      end
    end
  end

  // Capture read data into the owner's register; stores leave it untouched
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else if (capture && !ram_we) begin
      if (owner == OWN_MEM) begin
        mem_rdata <= ram_rdata;
      end else begin
        if_rdata <= ram_rdata;
      end
    end
  end

  assign ram_en    = (state == ST_ISSUE);
  assign if_ready  = (state == ST_DONE) && (owner == OWN_IF);
  assign mem_ready = (state == ST_DONE) && (owner == OWN_MEM);
  assign stall     = (if_req & ~if_ready) | (mem_req & ~mem_ready);

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter (LAT=2 and LAT=1)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;
  logic        if_ready, mem_ready, ram_en, ram_we, stall;

  logic        b_if_req, b_mem_req, b_mem_we;
  logic [31:0] b_if_addr, b_mem_addr, b_mem_wdata;
  logic [31:0] b_if_rdata, b_mem_rdata, b_ram_addr, b_ram_wdata, b_ram_rdata;
  logic        b_if_ready, b_mem_ready, b_ram_en, b_ram_we, b_stall;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LAT(LAT), .AW(32), .DW(32)) dut (
    .Clock(clk), .Reset(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .stall(stall)
  );

  mem_port_arbiter #(.LAT(1), .AW(32), .DW(32)) dut_lat1 (
    .Clock(clk), .Reset(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .mem_ready(b_mem_ready),
    .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
    .ram_rdata(b_ram_rdata), .stall(b_stall)
  );

  // RAM macro stand-ins: data registered on the access strobe
  logic [31:0] ram [0:255];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr[9:2]] <= ram_wdata;
      else        ram_rdata <= ram[ram_addr[9:2]];
    end
  end
  always @(posedge clk) begin
    if (b_ram_en) b_ram_rdata <= b_ram_addr ^ 32'hA5A5_A5A5;
  end

  function automatic logic [31:0] init_word(input int idx);
    return 32'h1000_0000 + 32'(idx * 4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [31:0] mdl_mem [0:255];
  bit          m_busy = 1'b0;
  int          m_start = 0;
  bit          m_own = 1'b0;
  bit          m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rd = '0;
  logic [31:0] m_if_rdata = '0, m_mem_rdata = '0;
  int          cyc = 0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = init_word(i);
      mdl_mem[i] = init_word(i);
    end
  end

  // An access granted in cycle t strobes the RAM in t+1 and completes in t+LAT+2
  task automatic m_begin(input bit own);
    m_busy  = 1'b1;
    m_start = cyc;
    m_own   = own;
    if (own) begin
      m_we = mem_we; m_addr = mem_addr; m_wdata = mem_wdata;
    end else begin
      m_we = 1'b0; m_addr = if_addr; m_wdata = '0;
    end
    if (m_we) mdl_mem[m_addr[9:2]] = m_wdata;
    else      m_rd = mdl_mem[m_addr[9:2]];
  endtask

  always @(negedge clk) begin
    logic exp_en, exp_ifr, exp_memr;
    if (rst) begin
      m_busy = 1'b0; m_if_rdata = '0; m_mem_rdata = '0;
      chk("m_rst_ram_en", ram_en, 0);
      chk("m_rst_ready", {if_ready, mem_ready}, 0);
      chk("m_rst_stall", stall, if_req | mem_req);
      chk("m_rst_rdata", if_rdata | mem_rdata, 0);
    end else begin
      exp_en   = m_busy && (cyc == m_start + 1);
      exp_ifr  = m_busy && !m_own && (cyc == m_start + LAT + 2);
      exp_memr = m_busy &&  m_own && (cyc == m_start + LAT + 2);
      if (exp_ifr && !m_we)  m_if_rdata  = m_rd;
      if (exp_memr && !m_we) m_mem_rdata = m_rd;
      chk("m_ram_en", ram_en, exp_en);
      chk("m_if_ready", if_ready, exp_ifr);
      chk("m_mem_ready", mem_ready, exp_memr);
      chk("m_stall", stall, (if_req & ~exp_ifr) | (mem_req & ~exp_memr));
      chk("m_if_rdata", if_rdata, m_if_rdata);
      chk("m_mem_rdata", mem_rdata, m_mem_rdata);
      if (exp_en) begin
        chk("m_ram_addr", ram_addr, m_addr);
        chk("m_ram_we", ram_we, m_we);
        if (m_we) chk("m_ram_wdata", ram_wdata, m_wdata);
      end
      if (!m_busy) begin
        if (mem_req)     m_begin(1'b1);
        else if (if_req) m_begin(1'b0);
      end else if (exp_ifr || exp_memr) begin
        if (m_own && if_req)        m_begin(1'b0);
        else if (!m_own && mem_req) m_begin(1'b1);
        else                        m_busy = 1'b0;
      end
    end
    cyc++;
  end

  // ---------------- directed stimulus ----------------
  // Raise one request right after a clock edge (cycle 0), wait for its ready,
  // drop it in the following cycle. Reports latency, strobe cycle/we, stall trace.
  task automatic access(input bit port, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output int en_cyc, output logic en_we, output logic [7:0] sh);
    if (port) begin
      mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    lat = -1; en_cyc = -1; en_we = 1'bx; sh = '0; rd = 'x;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i < 8) sh[i] = stall;
      if (ram_en && en_cyc < 0) begin
        en_cyc = i; en_we = ram_we;
      end
      if ((port && mem_ready) || (!port && if_ready)) begin
        lat = i;
        rd  = port ? mem_rdata : if_rdata;
        break;
      end
    end
    if (lat < 0) chk("access_timeout", 32'(lat), 32'(LAT + 2));
    @(posedge clk); #1;
    if (port) mem_req = 1'b0; else if_req = 1'b0;
  endtask

  initial begin
    int          lat, en_cyc, mr, ir, en1, en2, en_cnt, n, stray, blat;
    logic [31:0] rd, rd_m, rd_i, brd;
    logic        en_we;
    logic [7:0]  sh;
    logic [3:0]  ord;

    rst = 1'b1;
    if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    b_if_req = 1'b0; b_if_addr = '0; b_mem_req = 1'b0; b_mem_we = 1'b0;
    b_mem_addr = '0; b_mem_wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_ram_en", ram_en, 0);
    chk("reset_ram_addr", ram_addr, 0);
    chk("reset_if_rdata", if_rdata, 0);
    chk("reset_stall", stall, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // single fetch
    access(1'b0, 1'b0, 32'h0000_0004, '0, lat, rd, en_cyc, en_we, sh);
    chk("fetch_latency", 32'(lat), 4);
    chk("fetch_en_cycle", 32'(en_cyc), 1);
    chk("fetch_rdata", rd, 32'h1000_0004);
    chk("fetch_stall_trace", {27'd0, sh[4:0]}, 32'h0000_000F);

    // store then load
    access(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, lat, rd, en_cyc, en_we, sh);
    chk("store_latency", 32'(lat), 4);
    chk("store_ram_we", en_we, 1);
    access(1'b1, 1'b0, 32'h0000_0100, '0, lat, rd, en_cyc, en_we, sh);
    chk("load_latency", 32'(lat), 4);
    chk("load_ram_we", en_we, 0);
    chk("load_rdata", rd, 32'hDEAD_BEEF);

    // contention
    if_req = 1'b1; if_addr = 32'h8; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    mr = -1; ir = -1; en1 = -1; en2 = -1; en_cnt = 0; rd_m = 'x; rd_i = 'x;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (ram_en) begin
        en_cnt++;
        if (en1 < 0) en1 = i; else if (en2 < 0) en2 = i;
      end
      if (mem_ready && mr < 0) begin mr = i; rd_m = mem_rdata; end
      if (if_ready && ir < 0)  begin ir = i; rd_i = if_rdata; end
      @(posedge clk); #1;
      if (mr == i) mem_req = 1'b0;
      if (ir == i) if_req = 1'b0;
    end
    chk("cont_mem_ready_cyc", 32'(mr), 4);
    chk("cont_if_en_cyc", 32'(en2), 5);
    chk("cont_if_ready_cyc", 32'(ir), 8);
    chk("cont_first_en_cyc", 32'(en1), 1);
    chk("cont_en_count", 32'(en_cnt), 2);
    chk("cont_mem_rdata", rd_m, 32'hDEAD_BEEF);
    chk("cont_if_rdata", rd_i, 32'h1000_0008);

    // alternation with both requests held
    if_req = 1'b1; if_addr = 32'hC; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    ord = '0; n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_ready)     begin ord = {ord[2:0], 1'b1}; n++; end
      else if (if_ready) begin ord = {ord[2:0], 1'b0}; n++; end
      if (n == 4) break;
    end
    @(posedge clk); #1;
    if_req = 1'b0; mem_req = 1'b0;
    chk("alt_count", 32'(n), 4);
    chk("alt_order", {28'd0, ord}, 32'hA);
    repeat (8) @(posedge clk);
    #1;

    // reset in the middle of a load
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ram_en", ram_en, 0);
    chk("midrst_mem_ready", mem_ready, 0);
    chk("midrst_mem_rdata", mem_rdata, 0);
    chk("midrst_if_rdata", if_rdata, 0);
    chk("midrst_stall", stall, 1);
    @(posedge clk); #1;
    mem_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_ready || if_ready || ram_en) stray++;
    end
    chk("midrst_no_activity", 32'(stray), 0);
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'h0000_0100, '0, lat, rd, en_cyc, en_we, sh);
    chk("postrst_latency", 32'(lat), 4);
    chk("postrst_rdata", rd, 32'hDEAD_BEEF);

    // LAT=1 instance
    b_mem_req = 1'b1; b_mem_we = 1'b0; b_mem_addr = 32'h40;
    blat = -1; brd = 'x;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b_mem_ready) begin blat = i; brd = b_mem_rdata; break; end
    end
    @(posedge clk); #1;
    b_mem_req = 1'b0;
    chk("lat1_latency", 32'(blat), 3);
    chk("lat1_rdata", brd, 32'hA5A5_A5E5);
    @(negedge clk);
    chk("lat1_stall_idle", b_stall, 0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
